// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, FSM states, symbol width.
// Used by the decoder slice and reusable by the encoder side.
package tmds_pkg;

  localparam int SYM_W = 10;

  // Control tokens indexed by the 2-bit {V,H} code
  localparam logic [SYM_W-1:0] CTRL_TOK [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  typedef enum logic [1:0] {
    HUNT,
    SLIP,
    SETTLE,
    LOCKED
  } state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: i_sym -> {o_is_ctrl, o_code, o_data}.
// Ports: i_sym (10b symbol), o_is_ctrl, o_code (2b), o_data (8b).
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] i_sym,
  output logic             o_is_ctrl,
  output logic [1:0]       o_code,
  output logic [7:0]       o_data
);

  logic [7:0] w_d;

  assign w_d = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];

  always_comb begin
    o_is_ctrl = 1'b0;
    o_code    = 2'b00;
    for (int c = 0; c < 4; c++) begin
      if (i_sym == CTRL_TOK[c]) begin
        o_is_ctrl = 1'b1;
        o_code    = 2'(c);
      end
    end
  end

  // bit8 selects XOR (1) or XNOR (0) chaining
  always_comb begin
    o_data[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      o_data[i] = i_sym[8] ? (w_d[i] ^ w_d[i-1])
                           : ~(w_d[i] ^ w_d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: token-run alignment with bitslip, 2-stage decode.
// Ports: clklow, reset (async low), sym_valid/sym_in in; bitslip, locked,
// out_valid, de, pix_data, H_VSync_Ctr, err_cnt out.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_CTRL_RUN = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int SLIP_SETTLE   = 16,
  parameter int ERR_W         = 16
) (
  input  logic             clklow,
  input  logic             reset,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_in,
  output logic             bitslip,
  output logic             locked,
  output logic             out_valid,
  output logic             de,
  output logic [7:0]       pix_data,
  output logic [1:0]       H_VSync_Ctr,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_W = $clog2(LOCK_CTRL_RUN + 1);
  localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int SET_W = $clog2(SLIP_SETTLE + 1);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CTRL_RUN);
  localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(LOCK_CTRL_RUN - 1);
  localparam logic [WIN_W-1:0] WIN_PRE = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [SET_W-1:0] SET_PRE = SET_W'(SLIP_SETTLE - 1);

  state_e           r_state, w_state_nxt;
  logic [RUN_W-1:0] r_run, w_run_nxt;
  logic [WIN_W-1:0] r_win, w_win_nxt;
  logic [SET_W-1:0] r_set, w_set_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;

  logic       w_is_ctrl;
  logic [1:0] w_code;
  logic [7:0] w_data;
  logic       w_qual, w_full, w_short, w_locked;

  logic       r_s1_vld, r_s1_ctrl;
  logic [1:0] r_s1_code;
  logic [7:0] r_s1_data;
  logic       r_s2_vld, r_de;
  logic [7:0] r_pix;
  logic [1:0] r_hv;

  tmds_symbol_decode u_dec (
    .i_sym     (sym_in),
    .o_is_ctrl (w_is_ctrl),
    .o_code    (w_code),
    .o_data    (w_data)
  );

  // Run completion beats a window expiry on the same symbol
  assign w_qual  = sym_valid & w_is_ctrl & (r_run == RUN_PRE);
  assign w_full  = sym_valid & ~w_qual & (r_win == WIN_PRE);
  assign w_short = sym_valid & ~w_is_ctrl
                 & (r_run != '0) & (r_run != RUN_MAX);
  assign w_locked = (r_state == LOCKED);

  always_ff @(posedge clklow or negedge reset) begin
    if (!reset) begin
      r_state <= HUNT;
      r_run   <= '0;
      r_win   <= '0;
      r_set   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_win   <= w_win_nxt;
      r_set   <= w_set_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_win_nxt   = r_win;
    w_set_nxt   = r_set;
    w_err_nxt   = r_err;
    bitslip     = 1'b0;
    if (sym_valid && (r_state == HUNT || w_locked)) begin
      if (!w_is_ctrl)
        w_run_nxt = '0;
      else if (r_run != RUN_MAX)
        w_run_nxt = r_run + RUN_W'(1);
      w_win_nxt = (w_qual | w_full) ? '0 : r_win + WIN_W'(1);
    end
    unique case (r_state)
      HUNT: begin
        if (w_qual)
          w_state_nxt = LOCKED;
        else if (w_full)
          w_state_nxt = SLIP;
      end
      SLIP: begin
        bitslip     = 1'b1;
        w_run_nxt   = '0;
        w_win_nxt   = '0;
        w_set_nxt   = '0;
        w_state_nxt = SETTLE;
      end
      SETTLE: begin
        if (sym_valid) begin
          if (r_set == SET_PRE) begin
            w_set_nxt   = '0;
            w_state_nxt = HUNT;
          end else begin
            w_set_nxt = r_set + SET_W'(1);
          end
        end
      end
      LOCKED: begin
        if (w_short && !(&r_err))
          w_err_nxt = r_err + ERR_W'(1);
        if (w_full)
          w_state_nxt = HUNT;
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // Stage 1: symbol fields and classification
  always_ff @(posedge clklow or negedge reset) begin
    if (!reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_ctrl <= 1'b0;
      r_s1_code <= '0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= sym_valid;
      if (sym_valid) begin
        r_s1_ctrl <= w_is_ctrl;
        r_s1_code <= w_code;
        r_s1_data <= w_data;
      end
    end
  end

  // Stage 2: decoded outputs, only advanced while aligned
  always_ff @(posedge clklow or negedge reset) begin
    if (!reset) begin
      r_s2_vld <= 1'b0;
      r_de     <= 1'b0;
      r_pix    <= '0;
      r_hv     <= '0;
    end else begin
      r_s2_vld <= r_s1_vld & w_locked;
      if (r_s1_vld && w_locked) begin
        r_de  <= ~r_s1_ctrl;
        r_pix <= r_s1_ctrl ? 8'h00 : r_s1_data;
        if (r_s1_ctrl)
          r_hv <= r_s1_code;
      end
    end
  end

  assign locked      = w_locked;
  assign out_valid   = r_s2_vld & w_locked;
  assign de          = r_de;
  assign pix_data    = r_pix;
  assign H_VSync_Ctr = r_hv;
  assign err_cnt     = r_err;

endmodule
